// File: rtl/ram_fifo_ctrl_if.sv
`default_nettype none
// ============================================================================
// ram_fifo_ctrl_if : producer/consumer/RAM-port bundle for ram_fifo_ctrl
// Rev 1.0
// ============================================================================
interface ram_fifo_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic              ram_wr;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wr_data;
  logic [DATA_W-1:0] ram_rd_data;
  logic [ADDR_W:0]   level;

  // slave: the FIFO controller itself
  modport slave (
    input  in_valid, in_data, out_ready, ram_rd_data,
    output in_ready, out_valid, out_data, ram_wr, ram_addr, ram_wr_data, level
  );

  // master: producer, consumer and RAM around the controller
  modport master (
    output in_valid, in_data, out_ready, ram_rd_data,
    input  in_ready, out_valid, out_data, ram_wr, ram_addr, ram_wr_data, level
  );
endinterface
`default_nettype wire

// File: rtl/ram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// ram_fifo_ctrl : valid/ready FIFO using a single-port async-read RAM as
//                 storage, with a registered output stage and empty bypass
// Rev 1.0
// ============================================================================
module ram_fifo_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 4
) (
  input  logic           clk,
  input  logic           rst,
  ram_fifo_ctrl_if.slave bus_io
);

  localparam logic [ADDR_W-1:0] c_PTR_LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   c_DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   ram_cnt_q, ram_cnt_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  logic w_pop, w_slot, w_ram_empty, w_fill, w_byp, w_in_ready, w_write;

  function automatic logic [ADDR_W-1:0] f_ptr_inc(input logic [ADDR_W-1:0] p);
    return (p == c_PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign w_pop       = out_valid_q && bus_io.out_ready;
  assign w_slot      = !out_valid_q || w_pop;
  assign w_ram_empty = (ram_cnt_q == '0);
  assign w_fill      = w_slot && !w_ram_empty;
  assign w_byp       = w_slot && w_ram_empty;
  // A fill owns the single RAM port, so the producer is stalled for that cycle.
  assign w_in_ready  = !rst && (w_byp || (!w_fill && (ram_cnt_q < c_DEPTH_CNT)));
  assign w_write     = bus_io.in_valid && w_in_ready && !w_byp;

  assign bus_io.in_ready    = w_in_ready;
  assign bus_io.ram_wr      = w_write;
  assign bus_io.ram_addr    = w_write ? wr_ptr_q : rd_ptr_q;
  assign bus_io.ram_wr_data = bus_io.in_data;
  assign bus_io.out_valid   = out_valid_q;
  assign bus_io.out_data    = out_data_q;
  assign bus_io.level       = level_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ram_cnt_d   = ram_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (w_fill) begin
      out_data_d  = bus_io.ram_rd_data;
      out_valid_d = 1'b1;
      rd_ptr_d    = f_ptr_inc(rd_ptr_q);
      ram_cnt_d   = ram_cnt_q - 1'b1;
    end else if (w_byp && bus_io.in_valid) begin
      out_data_d  = bus_io.in_data;
      out_valid_d = 1'b1;
    end else if (w_pop) begin
      out_valid_d = 1'b0;
    end

    if (w_write) begin
      wr_ptr_d  = f_ptr_inc(wr_ptr_q);
      ram_cnt_d = ram_cnt_q + 1'b1;
    end

    level_d = ram_cnt_d + {{ADDR_W{1'b0}}, out_valid_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_cnt_q   <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_cnt_q   <= ram_cnt_d;
      level_q     <= level_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// tb_ram_fifo_ctrl : directed scenarios plus random traffic against a
//                    queue-based reference model of the FIFO
// Rev 1.0
// ============================================================================
module tb_ram_fifo_ctrl;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 4;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  ram_fifo_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  ram_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus.slave)
  );

  // Behavioural RAM: async read, synchronous write
  logic [7:0] mem [8];
  assign bus.ram_rd_data = mem[bus.ram_addr];
  always @(posedge clk) if (bus.ram_wr === 1'b1) mem[bus.ram_addr] <= bus.ram_wr_data;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: words held in RAM, the output word, and the accepted stream
  logic [7:0] ramq [$];
  logic [7:0] gold [$];
  bit         m_ov;
  logic [7:0] m_od;
  int         m_wp, m_rp;
  bit         e_pop, e_fill, e_byp, e_in_ready, e_wr;
  logic [2:0] e_addr;
  logic [7:0] e_pop_data;

  logic       s_in_ready, s_wr, s_out_valid;
  logic [2:0] s_addr;
  logic [7:0] s_out_data;
  logic [7:0] outs [$];
  bit         acc;

  function automatic void model_eval();
    bit slot;
    slot       = !m_ov || bus.out_ready;
    e_pop      = m_ov && bus.out_ready && !rst;
    e_fill     = slot && ramq.size() != 0;
    e_byp      = slot && ramq.size() == 0;
    e_in_ready = !rst && (e_byp || (!e_fill && ramq.size() < DEPTH));
    e_wr       = bus.in_valid && e_in_ready && !e_byp;
    e_addr     = e_wr ? 3'(m_wp) : 3'(m_rp);
  endfunction

  function automatic void model_update();
    if (rst) begin
      ramq.delete(); gold.delete();
      m_ov = 0; m_od = 8'h00; m_wp = 0; m_rp = 0;
    end else begin
      if (bus.in_valid && e_in_ready) gold.push_back(bus.in_data);
      if (e_fill) begin
        m_od = ramq.pop_front(); m_ov = 1; m_rp = (m_rp + 1) % DEPTH;
      end else if (e_byp && bus.in_valid) begin
        m_od = bus.in_data; m_ov = 1;
      end else if (e_pop) begin
        m_ov = 0;
      end
      if (e_wr) begin
        ramq.push_back(bus.in_data); m_wp = (m_wp + 1) % DEPTH;
      end
    end
  endfunction

  // One clock: drive inputs after the falling edge, sample Mealy outputs, step
  task automatic cyc(input logic r, input logic v, input logic [7:0] d, input logic ordy);
    rst = r; bus.in_valid = v; bus.in_data = d; bus.out_ready = ordy;
    #1;
    model_eval();
    s_in_ready  = bus.in_ready;
    s_wr        = bus.ram_wr;
    s_addr      = bus.ram_addr;
    s_out_valid = bus.out_valid;
    s_out_data  = bus.out_data;
    e_pop_data  = (e_pop && gold.size() != 0) ? gold.pop_front() : 8'hxx;
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    cyc(1, 0, 8'h00, 0);
    cyc(1, 0, 8'h00, 0);
  endtask

  // Consumer with out_ready high, optionally offering one word; gathers outputs
  task automatic consume(input int n, input int maxc, input logic v, input logic [7:0] d);
    logic pend;
    pend = v;
    outs.delete(); acc = 0;
    for (int c = 0; c < maxc && outs.size() < n; c++) begin
      cyc(0, pend, d, 1);
      if (s_out_valid === 1'b1) outs.push_back(s_out_data);
      if (pend && s_in_ready === 1'b1) begin pend = 0; acc = 1; end
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      cyc(1, 1'($urandom), 8'($urandom), 1'($urandom));
      checks++; if (s_wr !== 1'b0) begin errors++; $display("FAIL reset_ram_wr got=%b exp=0", s_wr); end
      checks++; if (s_in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", s_in_ready); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
      checks++; if (bus.level !== 4'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", bus.level); end
    end
    checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got=%h exp=00", bus.out_data); end
    cyc(0, 0, 8'h00, 1'($urandom));
    checks++; if (s_in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got=%b exp=1", s_in_ready); end
  endtask

  task automatic test_bypass();
    apply_reset();
    cyc(0, 1, 8'hA5, 0);
    checks++; if (s_in_ready !== 1'b1 || s_wr !== 1'b0) begin errors++; $display("FAIL bypass_accept in_ready=%b ram_wr=%b exp 1/0", s_in_ready, s_wr); end
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5) begin errors++; $display("FAIL bypass_out valid=%b data=%h exp 1/a5", bus.out_valid, bus.out_data); end
    checks++; if (bus.level !== 4'd1) begin errors++; $display("FAIL bypass_level got=%0d exp=1", bus.level); end
    cyc(0, 0, 8'h00, 0);
    checks++; if (s_wr !== 1'b0) begin errors++; $display("FAIL bypass_ram_wr got=%b exp=0", s_wr); end
    consume(1, 5, 0, 8'h00);
    checks++; if (outs.size() != 1 || outs[0] !== 8'hA5) begin errors++; $display("FAIL bypass_drain n=%0d exp 1 word a5", outs.size()); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bypass_empty out_valid=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_fill_full();
    logic [7:0] d;
    int n_acc;
    apply_reset();
    d = 8'h10; n_acc = 0;
    for (int c = 0; c < 20 && n_acc < 5; c++) begin
      cyc(0, 1, d, 0);
      if (s_in_ready === 1'b1) begin
        checks++;
        if (d == 8'h10 ? (s_wr !== 1'b0) : (s_wr !== 1'b1 || s_addr !== 3'(d - 8'h11))) begin
          errors++; $display("FAIL fill_write data=%h ram_wr=%b addr=%0d", d, s_wr, s_addr);
        end
        d = d + 8'h01; n_acc++;
      end
    end
    checks++; if (n_acc != 5) begin errors++; $display("FAIL fill_accept got=%0d exp=5", n_acc); end
    cyc(0, 1, 8'h15, 0);
    checks++; if (s_in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got=%b exp=0", s_in_ready); end
    checks++; if (bus.level !== 4'd5) begin errors++; $display("FAIL full_level got=%0d exp=5", bus.level); end
    consume(6, 40, 1, 8'h15);
    checks++; if (outs.size() != 6 || !acc) begin errors++; $display("FAIL full_drain n=%0d acc=%0d exp 6/1", outs.size(), acc); end
    for (int i = 0; i < outs.size(); i++) begin
      checks++; if (outs[i] !== 8'(8'h10 + i)) begin errors++; $display("FAIL full_order idx=%0d got=%h exp=%h", i, outs[i], 8'(8'h10 + i)); end
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      cyc(0, 1, 8'(1 + k), 0);
      checks++;
      if (s_in_ready !== 1'b1 || s_wr !== (k != 0) || (k != 0 && s_addr !== 3'(k - 1))) begin
        errors++; $display("FAIL wrap_wr1 k=%0d ram_wr=%b addr=%0d", k, s_wr, s_addr);
      end
    end
    consume(4, 20, 0, 8'h00);
    checks++; if (outs.size() != 4) begin errors++; $display("FAIL wrap_drain1 n=%0d exp=4", outs.size()); end
    for (int i = 0; i < outs.size(); i++) begin
      checks++; if (outs[i] !== 8'(1 + i)) begin errors++; $display("FAIL wrap_order1 idx=%0d got=%h exp=%h", i, outs[i], 8'(1 + i)); end
    end
    for (int k = 0; k < 4; k++) begin
      cyc(0, 1, 8'(5 + k), 0);
      checks++;
      if (s_in_ready !== 1'b1 || s_wr !== (k != 0) || (k != 0 && s_addr !== 3'((k + 2) % 4))) begin
        errors++; $display("FAIL wrap_wr2 k=%0d ram_wr=%b addr=%0d exp=%0d", k, s_wr, s_addr, (k + 2) % 4);
      end
    end
    consume(4, 20, 0, 8'h00);
    checks++; if (outs.size() != 4) begin errors++; $display("FAIL wrap_drain2 n=%0d exp=4", outs.size()); end
    for (int i = 0; i < outs.size(); i++) begin
      checks++; if (outs[i] !== 8'(5 + i)) begin errors++; $display("FAIL wrap_order2 idx=%0d got=%h exp=%h", i, outs[i], 8'(5 + i)); end
    end
  endtask

  task automatic test_simul_push_pop();
    logic exp_rdy;
    apply_reset();
    for (int k = 0; k < 3; k++) cyc(0, 1, 8'(8'h21 + k), 0);
    checks++; if (bus.level !== 4'd3) begin errors++; $display("FAIL simul_level got=%0d exp=3", bus.level); end
    for (int c = 0; c < 3; c++) begin
      cyc(0, 1, 8'h33, 1);
      exp_rdy = (c == 2);
      checks++;
      if (s_in_ready !== exp_rdy || s_wr !== 1'b0 || s_out_valid !== 1'b1 || s_out_data !== 8'(8'h21 + c)) begin
        errors++; $display("FAIL simul_cycle c=%0d in_ready=%b ram_wr=%b out=%h exp rdy=%b out=%h", c, s_in_ready, s_wr, s_out_data, exp_rdy, 8'(8'h21 + c));
      end
    end
    consume(1, 5, 0, 8'h00);
    checks++; if (outs.size() != 1 || outs[0] !== 8'h33) begin errors++; $display("FAIL simul_bypass n=%0d exp one word 33", outs.size()); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int k = 0; k < 3; k++) cyc(0, 1, 8'(8'h41 + k), 0);
    checks++; if (bus.level !== 4'd3) begin errors++; $display("FAIL mid_level_pre got=%0d exp=3", bus.level); end
    cyc(1, 0, 8'h00, 0);
    checks++; if (bus.level !== 4'd0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset level=%0d valid=%b exp 0/0", bus.level, bus.out_valid); end
    cyc(0, 1, 8'h77, 0);
    consume(1, 5, 0, 8'h00);
    checks++; if (outs.size() != 1 || outs[0] !== 8'h77) begin errors++; $display("FAIL mid_first_out n=%0d exp one word 77", outs.size()); end
  endtask

  task automatic test_random();
    logic       r, v, ordy;
    logic [7:0] d;
    apply_reset();
    v = 0; d = 8'h00;
    for (int c = 0; c < 600; c++) begin
      r = ($urandom_range(0, 99) == 0);
      // Producer keeps an unaccepted word stable; otherwise picks fresh stimulus
      if (!(v && !acc)) begin
        v = ($urandom_range(0, 99) < 60);
        d = 8'($urandom);
      end
      ordy = ($urandom_range(0, 99) < 45);
      cyc(r, v, d, ordy);
      acc = (s_in_ready === 1'b1) || r;
      checks++; if (s_in_ready !== e_in_ready) begin errors++; $display("FAIL rnd_in_ready c=%0d got=%b exp=%b", c, s_in_ready, e_in_ready); end
      checks++; if (s_wr !== e_wr) begin errors++; $display("FAIL rnd_ram_wr c=%0d got=%b exp=%b", c, s_wr, e_wr); end
      if (!r) begin
        checks++; if (s_addr !== e_addr) begin errors++; $display("FAIL rnd_ram_addr c=%0d got=%0d exp=%0d", c, s_addr, e_addr); end
      end
      if (e_pop) begin
        checks++; if (s_out_data !== e_pop_data) begin errors++; $display("FAIL rnd_pop_data c=%0d got=%h exp=%h", c, s_out_data, e_pop_data); end
      end
      checks++; if (bus.out_valid !== m_ov) begin errors++; $display("FAIL rnd_out_valid c=%0d got=%b exp=%b", c, bus.out_valid, m_ov); end
      checks++; if (bus.level !== 4'(ramq.size() + int'(m_ov))) begin errors++; $display("FAIL rnd_level c=%0d got=%0d exp=%0d", c, bus.level, ramq.size() + int'(m_ov)); end
      if (m_ov) begin
        checks++; if (bus.out_data !== m_od) begin errors++; $display("FAIL rnd_out_data c=%0d got=%h exp=%h", c, bus.out_data, m_od); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);
    rst = 1'b1; bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_bypass();
    test_fill_full();
    test_wrap();
    test_simul_push_pop();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
